stepper_move_arbiter: RTL and testbench

Shares one step/dir stepper driver between two move requesters (A: button jog, B: encoder command). Each requester posts a step count and direction over a req/ack/done handshake. The block arbitrates round-robin and enforces direction setup time. It generates fixed-width step pulses and reports move completion or abort. It sits between the request sources and the motor driver pins.

---
 rtl/stepper_move_arbiter.sv | 222 ++++++++++++++++++++++
 tb/tb_stepper_move_arbiter.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/stepper_move_arbiter.sv
// stepper_move_arbiter: shares one step/dir driver between requester A (jog) and B (encoder), round-robin.
// Latency: ack/busy/owner/dir one cycle after the req sample; first step rise with ack, or DIR_SETUP later on a dir change.
// Backpressure: no queueing; a req held while busy waits for IDLE, a req dropped before grant is lost.
//
// Optional feature macro: STEPPER_POS_TRACK_EN (adds signed 32-bit pos output and its counter).
// Ports:
//   CLOCK_50, rst_n             clock, asynchronous active-low reset
//   req_x/cnt_x/dir_x (x=a,b)   level move request, step count, direction (1 = CW)
//   ack_x/done_x                one-cycle accept / finish pulses to each requester
//   abort, aborted              cut the active move short at a pulse boundary; aborted qualifies done
//   busy, owner                 move in progress (grant..done inclusive), 0 = A / 1 = B
//   dir, step                   registered driver pins
//   pos                         signed step position (STEPPER_POS_TRACK_EN only)
module stepper_move_arbiter #(
  parameter int PULSE_LENGTH = 2500,
  parameter int DIR_SETUP    = 250,
  parameter int CNT_W        = 16
) (
  input  logic             CLOCK_50,
  input  logic             rst_n,
  input  logic             req_a,
  input  logic [CNT_W-1:0] cnt_a,
  input  logic             dir_a,
  input  logic             req_b,
  input  logic [CNT_W-1:0] cnt_b,
  input  logic             dir_b,
  output logic             ack_a,
  output logic             ack_b,
  output logic             done_a,
  output logic             done_b,
  input  logic             abort,
  output logic             aborted,
  output logic             busy,
  output logic             owner,
  output logic             dir,
  output logic             step
`ifdef STEPPER_POS_TRACK_EN
  ,
  output logic signed [31:0] pos
`endif
);

  localparam int SEG_MAX = (PULSE_LENGTH > DIR_SETUP) ? PULSE_LENGTH : DIR_SETUP;
  localparam int SEG_W   = (SEG_MAX > 1) ? $clog2(SEG_MAX) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_HIGH,
    S_LOW,
    S_DONE
  } state_t;

  state_t           state, state_nxt;
  logic [SEG_W-1:0] seg_cnt, seg_nxt;
  logic [CNT_W-1:0] rem, rem_nxt;
  logic             abort_pend, abort_pend_nxt;
  logic             zero_pend, zero_pend_nxt;
  logic             last_b, last_b_nxt;
  logic             owner_nxt, dir_nxt, busy_nxt, step_nxt;
  logic             ack_a_nxt, ack_b_nxt, done_nxt, aborted_nxt;

  // Grant selection: a lone request wins; on a tie the side not granted last wins.
  logic             pick_b;
  logic [CNT_W-1:0] mv_cnt;
  logic             mv_dir;

  assign pick_b = req_b & (~req_a | ~last_b);
  assign mv_cnt = pick_b ? cnt_b : cnt_a;
  assign mv_dir = pick_b ? dir_b : dir_a;

  always_comb begin
    state_nxt      = state;
    seg_nxt        = seg_cnt;
    rem_nxt        = rem;
    abort_pend_nxt = abort_pend;
    zero_pend_nxt  = zero_pend;
    last_b_nxt     = last_b;
    owner_nxt      = owner;
    dir_nxt        = dir;
    busy_nxt       = busy;
    ack_a_nxt      = 1'b0;
    ack_b_nxt      = 1'b0;
    done_nxt       = 1'b0;
    aborted_nxt    = 1'b0;

    case (state)
      S_IDLE: begin
        if (req_a || req_b) begin
          owner_nxt      = pick_b;
          last_b_nxt     = pick_b;
          ack_a_nxt      = ~pick_b;
          ack_b_nxt      = pick_b;
          busy_nxt       = 1'b1;
          rem_nxt        = mv_cnt;
          seg_nxt        = '0;
          abort_pend_nxt = 1'b0;
          if (mv_cnt == '0) begin
            // Zero-count move: spend one extra DONE cycle so ack and done never coincide.
            state_nxt     = S_DONE;
            zero_pend_nxt = 1'b1;
          end else if (mv_dir != dir) begin
            dir_nxt   = mv_dir;
            state_nxt = S_SETUP;
          end else begin
            state_nxt = S_HIGH;
          end
        end
      end

      S_SETUP: begin
        if (abort) begin
          state_nxt   = S_DONE;
          done_nxt    = 1'b1;
          aborted_nxt = 1'b1;
        end else if (seg_cnt == SEG_W'(DIR_SETUP - 1)) begin
          seg_nxt   = '0;
          state_nxt = S_HIGH;
        end else begin
          seg_nxt = seg_cnt + 1'b1;
        end
      end

      S_HIGH: begin
        // A pulse is never truncated: remember the abort and act after the low segment.
        if (abort) abort_pend_nxt = 1'b1;
        if (seg_cnt == SEG_W'(PULSE_LENGTH - 1)) begin
          seg_nxt   = '0;
          state_nxt = S_LOW;
        end else begin
          seg_nxt = seg_cnt + 1'b1;
        end
      end

      S_LOW: begin
        if (abort) begin
          state_nxt   = S_DONE;
          done_nxt    = 1'b1;
          aborted_nxt = 1'b1;
        end else if (seg_cnt == SEG_W'(PULSE_LENGTH - 1)) begin
          seg_nxt = '0;
          // Test for the last step before decrementing so a full-scale count cannot wrap.
          if (abort_pend || rem == CNT_W'(1)) begin
            state_nxt   = S_DONE;
            done_nxt    = 1'b1;
            aborted_nxt = abort_pend;
          end else begin
            rem_nxt   = rem - CNT_W'(1);
            state_nxt = S_HIGH;
          end
        end else begin
          seg_nxt = seg_cnt + 1'b1;
        end
      end

      S_DONE: begin
        if (zero_pend) begin
          zero_pend_nxt = 1'b0;
          done_nxt      = 1'b1;
        end else begin
          busy_nxt  = 1'b0;
          state_nxt = S_IDLE;
        end
      end

      default: begin
        state_nxt = S_IDLE;
        busy_nxt  = 1'b0;
      end
    endcase
  end

  assign step_nxt = (state_nxt == S_HIGH);

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      seg_cnt    <= '0;
      rem        <= '0;
      abort_pend <= 1'b0;
      zero_pend  <= 1'b0;
      last_b     <= 1'b1;
      owner      <= 1'b0;
      dir        <= 1'b1;
      busy       <= 1'b0;
      step       <= 1'b0;
      ack_a      <= 1'b0;
      ack_b      <= 1'b0;
      done_a     <= 1'b0;
      done_b     <= 1'b0;
      aborted    <= 1'b0;
    end else begin
      state      <= state_nxt;
      seg_cnt    <= seg_nxt;
      rem        <= rem_nxt;
      abort_pend <= abort_pend_nxt;
      zero_pend  <= zero_pend_nxt;
      last_b     <= last_b_nxt;
      owner      <= owner_nxt;
      dir        <= dir_nxt;
      busy       <= busy_nxt;
      step       <= step_nxt;
      ack_a      <= ack_a_nxt;
      ack_b      <= ack_b_nxt;
      done_a     <= done_nxt & ~owner_nxt;
      done_b     <= done_nxt & owner_nxt;
      aborted    <= aborted_nxt;
    end
  end

`ifdef STEPPER_POS_TRACK_EN
  // Count on the edge where step rises, using the direction driven with it.
  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      pos <= '0;
    end else if (step_nxt && !step) begin
      pos <= pos + (dir_nxt ? 32'sd1 : -32'sd1);
    end
  end
`endif

endmodule

// File: tb/tb_stepper_move_arbiter.sv
// Bench for stepper_move_arbiter: directed test-plan moves, randomized moves/aborts, mid-move reset.
// Expected timing is computed arithmetically from cycle offsets relative to the req sample.
// Cycle k = 1 is the first cycle after the edge that samples req.
module tb_stepper_move_arbiter;

  localparam int PL    = 10;
  localparam int DS    = 5;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             req_a, req_b, dir_a, dir_b, abort;
  logic [CNT_W-1:0] cnt_a, cnt_b;
  logic             ack_a, ack_b, done_a, done_b, aborted, busy, owner, dir, step;
`ifdef STEPPER_POS_TRACK_EN
  logic signed [31:0] pos;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit m_dir    = 1'b1;
  bit m_last_b = 1'b1;
  int m_pos    = 0;

  stepper_move_arbiter #(
    .PULSE_LENGTH(PL),
    .DIR_SETUP   (DS),
    .CNT_W       (CNT_W)
  ) dut (
    .CLOCK_50(clk),
    .rst_n   (rst_n),
    .req_a   (req_a),
    .cnt_a   (cnt_a),
    .dir_a   (dir_a),
    .req_b   (req_b),
    .cnt_b   (cnt_b),
    .dir_b   (dir_b),
    .ack_a   (ack_a),
    .ack_b   (ack_b),
    .done_a  (done_a),
    .done_b  (done_b),
    .abort   (abort),
    .aborted (aborted),
    .busy    (busy),
    .owner   (owner),
    .dir     (dir),
    .step    (step)
`ifdef STEPPER_POS_TRACK_EN
    ,
    .pos     (pos)
`endif
  );

  always #10 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  function automatic int setup_len(input int n, input bit d);
    return (n != 0 && d != m_dir) ? DS : 0;
  endfunction

  function automatic int move_len(input int n, input bit d);
    return (n == 0) ? 2 : 1 + setup_len(n, d) + 2 * PL * n;
  endfunction

  // mask: 1 = A, 2 = B, 3 = both. ab_j: cycle whose state sees abort (0 = none).
  task automatic run_move(input int mask, input int n, input bit d, input int ab_j);
    bit wb, exp_ab, got_ackb, got_doneb, got_ab, got_own, got_dir, got_busy, done_busy, after_busy;
    int setup, exp_done, exp_rises, p, idx, nack, ndone, ack_k, done_k;
    bit prev_step;
    int rises[$];
    int falls[$];

    wb        = (mask == 2) || (mask == 3 && !m_last_b);
    setup     = setup_len(n, d);
    exp_done  = move_len(n, d);
    exp_rises = n;
    exp_ab    = 1'b0;
    if (ab_j > 0 && n > 0) begin
      exp_ab = 1'b1;
      if (ab_j <= setup) begin
        exp_done  = ab_j + 1;
        exp_rises = 0;
      end else begin
        p         = ab_j - 1 - setup;
        idx       = p / (2 * PL);
        exp_rises = idx + 1;
        if (p % (2 * PL) < PL) exp_done = 1 + setup + 2 * PL * (idx + 1);
        else                   exp_done = ab_j + 1;
      end
    end

    nack = 0; ndone = 0; ack_k = -1; done_k = -1;
    got_ackb = 0; got_doneb = 0; got_ab = 0; got_own = 0; got_dir = 0; got_busy = 0;
    done_busy = 0; after_busy = 1;

    @(negedge clk);
    req_a = mask[0]; req_b = mask[1];
    cnt_a = CNT_W'(n); cnt_b = CNT_W'(n);
    dir_a = d; dir_b = d;
    prev_step = step;

    for (int k = 1; k <= exp_done + 5; k++) begin
      @(negedge clk);
      if (ack_a || ack_b) begin
        nack++; ack_k = k; got_ackb = ack_b;
        got_own = owner; got_dir = dir; got_busy = busy;
        req_a = 1'b0; req_b = 1'b0;
      end
      if (step && !prev_step) rises.push_back(k);
      if (!step && prev_step) falls.push_back(k);
      prev_step = step;
      if (done_a || done_b) begin
        ndone++; done_k = k; got_doneb = done_b; got_ab = aborted; done_busy = busy;
      end
      abort = (ab_j > 0 && k == ab_j);
      if (ndone > 0 && k == done_k + 1) begin
        after_busy = busy;
        break;
      end
    end
    abort = 1'b0; req_a = 1'b0; req_b = 1'b0;

    chk("ack_count", nack, 1);
    chk("ack_cycle", ack_k, 1);
    chk("ack_side", int'(got_ackb), int'(wb));
    chk("owner", int'(got_own), int'(wb));
    chk("busy_at_ack", int'(got_busy), 1);
    chk("dir_at_ack", int'(got_dir), int'((n != 0) ? d : m_dir));
    chk("done_count", ndone, 1);
    chk("done_cycle", done_k, exp_done);
    chk("done_side", int'(got_doneb), int'(wb));
    chk("aborted", int'(got_ab), int'(exp_ab));
    chk("busy_at_done", int'(done_busy), 1);
    chk("busy_after_done", int'(after_busy), 0);
    chk("rise_count", rises.size(), exp_rises);
    chk("fall_count", falls.size(), exp_rises);
    for (int i = 0; i < rises.size() && i < exp_rises; i++)
      chk("rise_cycle", rises[i], 1 + setup + 2 * PL * i);
    for (int i = 0; i < falls.size() && i < exp_rises; i++)
      chk("fall_cycle", falls[i], 1 + setup + 2 * PL * i + PL);

    m_last_b = wb;
    if (n != 0) m_dir = d;
    m_pos = m_pos + (d ? exp_rises : -exp_rises);
`ifdef STEPPER_POS_TRACK_EN
    chk("pos", int'(pos), m_pos);
`endif
  endtask

  initial begin
    bit seen_done, seen_step;
    int mask, n, ab_j;
    bit d;

    rst_n = 1'b0;
    req_a = 1'b0; req_b = 1'b0; abort = 1'b0;
    cnt_a = '0; cnt_b = '0; dir_a = 1'b0; dir_b = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_ack", int'({ack_a, ack_b}), 0);
    chk("rst_done", int'({done_a, done_b}), 0);
    chk("rst_aborted", int'(aborted), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_owner", int'(owner), 0);
    chk("rst_dir", int'(dir), 1);
    chk("rst_step", int'(step), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed test-plan moves
    run_move(1, 3, 1'b1, 0);            // A 3 CW, no setup, done at cycle 61
    run_move(2, 2, 1'b0, 0);            // B 2 CCW, dir change with setup
    run_move(3, 0, 1'b0, 0);            // tie -> A (B granted last)
    run_move(3, 0, 1'b0, 0);            // tie -> B
    run_move(1, 5, 1'b0, 1 + 2 * PL + 1); // abort one cycle into HIGH of pulse 2
    run_move(1, 0, 1'b1, 0);            // zero count, dir unchanged
    run_move(2, 3, 1'b1, 3);            // abort during SETUP
    run_move(1, 2, 1'b1, 1 + PL + 2);   // abort during LOW of pulse 1

    // Randomized moves and aborts
    for (int it = 0; it < 24; it++) begin
      mask = $urandom_range(1, 3);
      n    = $urandom_range(0, 4);
      d    = 1'($urandom_range(0, 1));
      ab_j = 0;
      if (n > 0 && $urandom_range(0, 2) == 0)
        ab_j = $urandom_range(1, move_len(n, d) - 1);
      run_move(mask, n, d, ab_j);
    end

    // Reset in the middle of a HIGH segment
    @(negedge clk);
    req_a = 1'b1; cnt_a = CNT_W'(3); dir_a = m_dir;
    @(negedge clk);
    req_a = 1'b0;
    repeat (3) @(negedge clk);
    chk("step_before_rst", int'(step), 1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_step", int'(step), 0);
    chk("rst_mid_busy", int'(busy), 0);
    chk("rst_mid_dir", int'(dir), 1);
    @(negedge clk);
    rst_n = 1'b1;
    m_dir = 1'b1; m_last_b = 1'b1; m_pos = 0;
    seen_done = 0; seen_step = 0;
    repeat (40) begin
      @(negedge clk);
      if (done_a || done_b) seen_done = 1;
      if (step || busy) seen_step = 1;
    end
    chk("no_done_after_rst", int'(seen_done), 0);
    chk("idle_after_rst", int'(seen_step), 0);

    // Moves after reset: 3 CW then 2 CCW
    run_move(1, 3, 1'b1, 0);
    run_move(1, 2, 1'b0, 0);
`ifdef STEPPER_POS_TRACK_EN
    chk("pos_final", int'(pos), 1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
